tmds_channel_decoder: RTL and testbench
=======================================

TMDS_CHANNEL_DECODER -- requirements
Module: tmds_channel_decoder

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 8: number of consecutive control-token windows needed to declare lock.
REQ-002 SHALL have parameter LOSS_TIMEOUT, default 1024: valid symbols allowed without a control token before lock drops.
REQ-003 SHALL have port clk_27M  input  1  sole clock, pixel clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sym_in  input  10  raw word from a 1:10 deserializer; bit 0 is the earliest received bit.
REQ-006 SHALL have port sym_valid  input  1  sym_in is valid this cycle.
REQ-007 SHALL have port data  output  8  decoded pixel byte.
REQ-008 SHALL have port ctrl  output  2  decoded control bits {c1,c0}.
REQ-009 SHALL have port de  output  1  1 = data symbol, 0 = control token.
REQ-010 SHALL have port out_valid  output  1  data/ctrl/de updated this cycle.
REQ-011 SHALL have port locked  output  1  word alignment established.
REQ-012 SHALL have port offset  output  4  current bit-alignment offset, 0..9.

Function
REQ-013 SHALL register prev = sym_in on every cycle with sym_valid=1; stream = {sym_in, prev} (20 bits).
REQ-014 SHALL form window = stream[19-offset : 10-offset]; offset 0 selects sym_in directly.
REQ-015 SHALL treat window as a control token only for 0x354 (ctrl 00), 0x0AB (01), 0x154 (10), 0x2AB (11).
REQ-016 SHALL decode a non-token window q: d = q[9] ? ~q[7:0] : q[7:0]; out[0] = d[0]; out[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]) for i = 1..7.
REQ-017 SHALL ignore cycles with sym_valid=0: no state, counter, offset, prev or output-register change; out_valid=0.
REQ-018 SHALL implement FSM states SEARCH, VERIFY, LOCKED, evaluated only on sym_valid=1.
REQ-019 SEARCH: window is token -> VERIFY with run=1; otherwise offset <- (offset+1) mod 10, remain in SEARCH.
REQ-020 VERIFY: window is token -> run+1; when run reaches LOCK_COUNT -> LOCKED, gap counter cleared; non-token -> SEARCH, offset <- (offset+1) mod 10, run=0.
REQ-021 LOCKED: token clears gap counter; non-token increments it; at LOSS_TIMEOUT consecutive non-tokens -> SEARCH, offset unchanged, gap=0.
REQ-022 SHALL assert locked exactly while the registered state is LOCKED.
REQ-023 SHALL register data/ctrl/de and pulse out_valid=1 one cycle after each valid symbol evaluated while state is LOCKED (latency 1).
REQ-024 SHALL write ctrl on tokens with data held; SHALL write data on data symbols with ctrl held; SHALL hold all three when out_valid=0.
REQ-025 SHALL produce no out_valid for the symbol whose evaluation causes the transition into LOCKED.
REQ-026 SHALL produce out_valid=1 for the symbol whose evaluation causes the transition out of LOCKED.
REQ-027 Offset wrap: 9 -> 0.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, force state SEARCH, offset=0, prev=0, run=0, gap=0, data=0x00, ctrl=0, de=0, out_valid=0, locked=0.
REQ-029 rst SHALL take priority over sym_valid; reset mid-lock drops locked on the next edge.

Verification
REQ-030 Reset: assert rst for 2 cycles with sym_valid=1 -> locked=0, out_valid=0, offset=0, data=0x00.
REQ-031 Aligned lock: feed 0x354 continuously -> locked=1 the cycle after the 8th valid symbol, offset=0; 9th symbol -> out_valid=1, ctrl=00, de=0.
REQ-032 Misaligned: stream of 0x354 tokens delayed by 3 bits -> locked=1 within 20 valid symbols, offset=3, ctrl=00.
REQ-033 Decode: after lock at offset 0 feed 0x1FF, 0x2FF, 0x2AB -> data=0x01 de=1; data=0xFE de=1; ctrl=11 de=0 (data held at 0xFE).
REQ-034 Verify fail: from SEARCH at offset 0 feed 5x 0x354 then 0x1FF -> SEARCH, offset=1, locked=0; sym_valid=0 gaps mid-run do not break the run.
REQ-035 Lock loss: after lock feed 1024 consecutive 0x1FF -> locked=0 the cycle after the 1024th, offset unchanged; 1023 then 0x354 keeps lock.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder. It aligns a 10-bit deserialized word stream on the control tokens.
// Once locked, it decodes data symbols and control tokens with one cycle of latency.
module tmds_channel_decoder #(
   parameter int LOCK_COUNT   = 8,
   parameter int LOSS_TIMEOUT = 1024
) (
   input  logic       clk_27M,
   input  logic       rst,
   input  logic [9:0] sym_in,
   input  logic       sym_valid,
   output logic [7:0] data,
   output logic [1:0] ctrl,
   output logic       de,
   output logic       out_valid,
   output logic       locked,
   output logic [3:0] offset
);

   localparam int RUN_W = $clog2(LOCK_COUNT + 1);
   localparam int GAP_W = $clog2(LOSS_TIMEOUT + 1);

   typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_t;

   state_t           r_state, w_state_nxt;
   logic [3:0]       r_offset, w_offset_nxt, w_offset_inc;
   logic [RUN_W-1:0] r_run, w_run_nxt, w_run_inc;
   logic [GAP_W-1:0] r_gap, w_gap_nxt, w_gap_inc;
   logic [9:0]       r_prev;
   logic [7:0]       r_data;
   logic [1:0]       r_ctrl;
   logic             r_de, r_out_valid;

   logic [19:0]      w_stream;
   logic [4:0]       w_base;
   logic [9:0]       w_window;
   logic             w_is_token;
   logic [1:0]       w_ctrl;
   logic [7:0]       w_d, w_data;

   // Offset k picks stream bits [19-k : 10-k], so offset 0 is sym_in as received.
   assign w_stream     = {sym_in, r_prev};
   assign w_base       = 5'd10 - {1'b0, r_offset};
   assign w_window     = w_stream[w_base +: 10];
   assign w_offset_inc = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
   assign w_run_inc    = r_run + 1'b1;
   assign w_gap_inc    = r_gap + 1'b1;

   // NOTE: every always_comb output gets a default first, so that no path infers a latch.
   always_comb begin
      w_is_token = 1'b1;
      w_ctrl     = 2'b00;
      case (w_window)
         10'h354: w_ctrl = 2'b00;
         10'h0AB: w_ctrl = 2'b01;
         10'h154: w_ctrl = 2'b10;
         10'h2AB: w_ctrl = 2'b11;
         default: w_is_token = 1'b0;
      endcase
   end

   always_comb begin
      w_d    = w_window[9] ? ~w_window[7:0] : w_window[7:0];
      w_data = 8'h00;
      w_data[0] = w_d[0];
      for (int i = 1; i < 8; i++)
         w_data[i] = w_window[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_offset_nxt = r_offset;
      w_run_nxt    = r_run;
      w_gap_nxt    = r_gap;
      if (sym_valid) begin
         case (r_state)
            ST_SEARCH: begin
               if (w_is_token) begin
                  w_state_nxt = ST_VERIFY;
                  w_run_nxt   = RUN_W'(1);
               end else begin
                  w_offset_nxt = w_offset_inc;
               end
            end
            ST_VERIFY: begin
               if (w_is_token) begin
                  w_run_nxt = w_run_inc;
                  if (w_run_inc == RUN_W'(LOCK_COUNT)) begin
                     w_state_nxt = ST_LOCKED;
                     w_gap_nxt   = '0;
                  end
               end else begin
                  w_state_nxt  = ST_SEARCH;
                  w_offset_nxt = w_offset_inc;
                  w_run_nxt    = '0;
               end
            end
            ST_LOCKED: begin
               if (w_is_token) begin
                  w_gap_nxt = '0;
               end else if (w_gap_inc == GAP_W'(LOSS_TIMEOUT)) begin
                  w_state_nxt = ST_SEARCH;
                  w_gap_nxt   = '0;
                  w_run_nxt   = '0;
               end else begin
                  w_gap_nxt = w_gap_inc;
               end
            end
            default: w_state_nxt = ST_SEARCH;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_27M) begin
      if (rst) begin
         r_state     <= ST_SEARCH;
         r_offset    <= 4'd0;
         r_run       <= '0;
         r_gap       <= '0;
         r_prev      <= 10'd0;
         r_data      <= 8'h00;
         r_ctrl      <= 2'b00;
         r_de        <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_offset    <= w_offset_nxt;
         r_run       <= w_run_nxt;
         r_gap       <= w_gap_nxt;
         r_out_valid <= 1'b0;
         if (sym_valid) begin
            r_prev <= sym_in;
            // The output follows the state before this symbol: no output on entry to lock, one output on exit.
            if (r_state == ST_LOCKED) begin
               r_out_valid <= 1'b1;
               r_de        <= ~w_is_token;
               if (w_is_token) r_ctrl <= w_ctrl;
               else            r_data <= w_data;
            end
         end
      end
   end

   assign data      = r_data;
   assign ctrl      = r_ctrl;
   assign de        = r_de;
   assign out_valid = r_out_valid;
   assign locked    = (r_state == ST_LOCKED);
   assign offset    = r_offset;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder. It covers reset, aligned and misaligned lock, decode,
// verify failure, offset wrap, loss of lock and reset while locked.
module tb_tmds_channel_decoder;

   logic       clk_27M = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] sym_in = 10'd0;
   logic       sym_valid = 1'b0;
   logic [7:0] data;
   logic [1:0] ctrl;
   logic       de, out_valid, locked;
   logic [3:0] offset;

   int n_checks = 0;
   int n_errors = 0;

   tmds_channel_decoder #(.LOCK_COUNT(8), .LOSS_TIMEOUT(1024)) dut (
      .clk_27M  (clk_27M),
      .rst      (rst),
      .sym_in   (sym_in),
      .sym_valid(sym_valid),
      .data     (data),
      .ctrl     (ctrl),
      .de       (de),
      .out_valid(out_valid),
      .locked   (locked),
      .offset   (offset)
   );

   always #5 clk_27M = ~clk_27M;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one valid symbol across a rising edge, then sample 1 time unit after that edge.
   task automatic send(input logic [9:0] s);
      @(negedge clk_27M);
      sym_in    = s;
      sym_valid = 1'b1;
      @(posedge clk_27M);
      #1;
      sym_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_27M);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_27M);
      rst       = 1'b1;
      sym_valid = 1'b1;
      sym_in    = 10'h354;
      repeat (2) @(posedge clk_27M);
      #1;
      rst       = 1'b0;
      sym_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] tok, rot;
      int         n_sent;

      // Reset is held with valid tokens on the input.
      do_reset();
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_ov",     32'(out_valid), 32'd0);
      check("rst_offset", 32'(offset), 32'd0);
      check("rst_data",   32'(data), 32'h00);

      // Aligned lock: the 8th token locks with no output, and the 9th token gives an output.
      repeat (7) send(10'h354);
      check("align_pre_lock", 32'(locked), 32'd0);
      send(10'h354);
      check("align_locked", 32'(locked), 32'd1);
      check("align_offset", 32'(offset), 32'd0);
      check("align_no_ov",  32'(out_valid), 32'd0);
      send(10'h354);
      check("align_ov",   32'(out_valid), 32'd1);
      check("align_ctrl", 32'(ctrl), 32'd0);
      check("align_de",   32'(de), 32'd0);

      // Decode checks. 0x1FF decodes to 0x01 and 0x2FF decodes to 0xFE. 0x2AB is ctrl 11 and leaves data unchanged.
      send(10'h1FF);
      check("dec1_ov",   32'(out_valid), 32'd1);
      check("dec1_data", 32'(data), 32'h01);
      check("dec1_de",   32'(de), 32'd1);
      check("dec1_ctrl", 32'(ctrl), 32'd0);
      send(10'h2FF);
      check("dec2_data", 32'(data), 32'hFE);
      check("dec2_de",   32'(de), 32'd1);
      send(10'h2AB);
      check("dec3_ctrl", 32'(ctrl), 32'd3);
      check("dec3_de",   32'(de), 32'd0);
      check("dec3_data", 32'(data), 32'hFE);
      idle(1);
      check("gap_ov",   32'(out_valid), 32'd0);
      check("gap_data", 32'(data), 32'hFE);
      check("gap_ctrl", 32'(ctrl), 32'd3);

      // Loss of lock: 1023 non-tokens followed by a token keep lock. 1024 non-tokens in a row drop it.
      repeat (1023) send(10'h1FF);
      check("loss_1023_locked", 32'(locked), 32'd1);
      send(10'h354);
      check("loss_tok_locked", 32'(locked), 32'd1);
      check("loss_tok_ctrl",   32'(ctrl), 32'd0);
      repeat (1023) send(10'h1FF);
      check("loss_pre_locked", 32'(locked), 32'd1);
      send(10'h1FF);
      check("loss_locked", 32'(locked), 32'd0);
      check("loss_ov",     32'(out_valid), 32'd1);
      check("loss_data",   32'(data), 32'h01);
      check("loss_offset", 32'(offset), 32'd0);

      // Relock, then assert reset for one edge while valid is high.
      repeat (8) send(10'h354);
      check("relock_locked", 32'(locked), 32'd1);
      @(negedge clk_27M);
      rst = 1'b1; sym_valid = 1'b1; sym_in = 10'h354;
      @(posedge clk_27M);
      #1;
      rst = 1'b0; sym_valid = 1'b0;
      check("midrst_locked", 32'(locked), 32'd0);
      check("midrst_ov",     32'(out_valid), 32'd0);
      check("midrst_data",   32'(data), 32'h00);

      // Verify failure: five tokens separated by idle cycles, then a data symbol.
      do_reset();
      for (int i = 0; i < 5; i++) begin
         send(10'h354);
         idle(2);
         check("vf_idle_ov", 32'(out_valid), 32'd0);
      end
      check("vf_offset_hold", 32'(offset), 32'd0);
      send(10'h1FF);
      check("vf_locked", 32'(locked), 32'd0);
      check("vf_offset", 32'(offset), 32'd1);

      // Idle cycles in the middle of a run do not break the run.
      do_reset();
      repeat (4) send(10'h354);
      idle(3);
      repeat (4) send(10'h354);
      check("gaprun_locked", 32'(locked), 32'd1);

      // Offset wraps from 9 back to 0 after ten non-tokens in SEARCH.
      do_reset();
      repeat (9) send(10'h1FF);
      check("wrap_offset9", 32'(offset), 32'd9);
      send(10'h1FF);
      check("wrap_offset0", 32'(offset), 32'd0);

      // Misaligned stream: each word is 0x354 rotated right by 3. The token lies in window bits [16:7].
      // Offsets 0..2 fail and offset 3 finds the token, then 7 more tokens are needed, so lock comes at symbol 11.
      do_reset();
      tok = 10'h354;
      rot = {tok[2:0], tok[9:3]};
      n_sent = 0;
      for (int i = 0; i < 20 && !locked; i++) begin
         send(rot);
         n_sent++;
      end
      check("mis_locked", 32'(locked), 32'd1);
      check("mis_count",  32'(n_sent), 32'd11);
      check("mis_offset", 32'(offset), 32'd3);
      send(rot);
      check("mis_ov",   32'(out_valid), 32'd1);
      check("mis_ctrl", 32'(ctrl), 32'd0);
      check("mis_de",   32'(de), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
